// File: rtl/char_tx_pkg.sv
// Shared types and constants for the character transmit sequencer:
// FSM state encoding, register map and STATUS bit positions.
`timescale 1ns/1ps
package char_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } char_tx_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  localparam int STAT_COMPLETE = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_FULL     = 2;
  localparam int STAT_BUSY     = 3;
  localparam int STAT_OVERFLOW = 4;

  // A zero divisor would stall the bit counter, so it is promoted to one.
  function automatic logic [15:0] sanitize_div(input logic [15:0] value);
    return (value == 16'd0) ? 16'd1 : value;
  endfunction

endpackage

// File: rtl/char_tx_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only when a pop
// frees the slot in the same cycle.
`timescale 1ns/1ps
module char_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/char_tx_sequencer.sv
// Avalon-MM slave that buffers CPU bytes and serializes them as 8N1 frames
// at a programmable bit period, flagging each completed frame.
`timescale 1ns/1ps
module char_tx_sequencer
  import char_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_serial,
  output logic        char_complete_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  char_tx_state_t state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] active_div_q, active_div_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        complete_q, complete_d;
  logic        overflow_q, overflow_d;

  logic          wr_en, push, status_wr, div_wr;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          bit_end, frame_done, busy;
  logic          unused_bits;

  assign wr_en     = chipselect && !write_n;
  assign push      = wr_en && (address == ADDR_DATA);
  assign status_wr = wr_en && (address == ADDR_STATUS);
  assign div_wr    = wr_en && (address == ADDR_DIV);
  assign bit_end   = (div_cnt_q == 16'd0);
  assign busy      = (state_q != ST_IDLE);

  assign unused_bits = ^{fifo_count, writedata[31:16]};

  char_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i (writedata[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA:  if (bit_end && bit_cnt_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
    frame_done = (state_q == ST_STOP) && bit_end;
  end

  // The divisor is latched at frame start so a DIV write only affects later frames.
  always_comb begin
    active_div_d = active_div_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          shift_d      = fifo_rdata;
          active_div_d = div_q;
          div_cnt_d    = div_q - 16'd1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          div_cnt_d = active_div_q - 16'd1;
          bit_cnt_d = 3'd0;
        end else begin
          div_cnt_d = div_cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          div_cnt_d = active_div_q - 16'd1;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          div_cnt_d = div_cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (!bit_end) div_cnt_d = div_cnt_q - 16'd1;
      end
      default: ;
    endcase

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (div_wr) div_d = sanitize_div(writedata[15:0]);

    complete_d = complete_q;
    if (status_wr && writedata[0]) complete_d = 1'b0;
    if (frame_done)                complete_d = 1'b1;

    overflow_d = overflow_q;
    if (status_wr && writedata[4])           overflow_d = 1'b0;
    if (push && fifo_full && !fifo_pop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= 16'(DEFAULT_DIV);
      active_div_q <= 16'(DEFAULT_DIV);
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      complete_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      div_q        <= div_d;
      active_div_q <= active_div_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      complete_q   <= complete_d;
      overflow_q   <= overflow_d;
    end
  end

  assign tx_serial        = tx_q;
  assign char_complete_tx = complete_q;

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_STATUS: begin
        readdata[STAT_COMPLETE] = complete_q;
        readdata[STAT_EMPTY]    = fifo_empty;
        readdata[STAT_FULL]     = fifo_full;
        readdata[STAT_BUSY]     = busy;
        readdata[STAT_OVERFLOW] = overflow_q;
      end
      ADDR_DIV: readdata = {16'd0, div_q};
      default:  readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_char_tx_sequencer.sv
// Scoreboard bench: stimulus queues the frames it expects, and a monitor
// decodes every frame on tx_serial and checks it cycle by cycle.
`timescale 1ns/1ps
module tb_char_tx_sequencer;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         chkComplete;
    bit         b2b;
  } frameExp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_serial;
  logic        char_complete_tx;

  frameExp_t expQ[$];
  int        testsRun    = 0;
  int        testsFailed = 0;
  bit        monActive   = 1'b1;

  char_tx_sequencer #(
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (434)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .address          (address),
    .chipselect       (chipselect),
    .write_n          (write_n),
    .writedata        (writedata),
    .readdata         (readdata),
    .tx_serial        (tx_serial),
    .char_complete_tx (char_complete_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    data = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pushFrame(input logic [7:0] data, input int div, input bit chkC, input bit b2b);
    frameExp_t e;
    e.data = data;
    e.div = div;
    e.chkComplete = chkC;
    e.b2b = b2b;
    expQ.push_back(e);
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    logic [31:0] st;
    bit done = 1'b0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      readReg(2'd1, st);
      if (st[3] == 1'b0 && st[1] == 1'b1) done = 1'b1;
    end
    if (!done) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Index 0 is the first low sample; the run ends at index 10*div, the first
  // cycle after STOP, where the complete flag must already be set.
  task automatic runFrame(input frameExp_t e);
    int errs = 0;
    logic [7:0] got = 8'd0;
    logic expv;
    for (int k = 1; k <= 10 * e.div; k++) begin
      @(negedge clk);
      if (k < e.div)           expv = 1'b0;
      else if (k < 9 * e.div)  expv = e.data[(k / e.div) - 1];
      else                     expv = 1'b1;
      if (tx_serial !== expv) errs++;
      for (int b = 0; b < 8; b++)
        if (k == e.div * (1 + b) + e.div / 2) got[b] = tx_serial;
      if (e.chkComplete && k == 10 * e.div - 1)
        checkOutput("complete_before_stop_end", {31'd0, char_complete_tx}, 32'd0);
      if (e.chkComplete && k == 10 * e.div)
        checkOutput("complete_at_stop_end", {31'd0, char_complete_tx}, 32'd1);
    end
    checkOutput("frame_wave_errors", errs, 32'd0);
    checkOutput("frame_byte", {24'd0, got}, {24'd0, e.data});
  endtask

  initial begin : monitor
    frameExp_t e;
    bit more;
    forever begin
      @(negedge clk);
      if (monActive && reset_n && tx_serial === 1'b0) begin
        more = 1'b1;
        while (more) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_frame", 32'd1, 32'd0);
            more = 1'b0;
          end else begin
            e = expQ.pop_front();
            runFrame(e);
            if (expQ.size() > 0 && expQ[0].b2b) begin
              @(negedge clk);
              checkOutput("b2b_one_cycle_gap", {31'd0, tx_serial}, 32'd0);
              more = (tx_serial === 1'b0);
            end else begin
              more = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus();
    logic [31:0] rd;

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("tx_in_reset", {31'd0, tx_serial}, 32'd1);
    reset_n = 1'b1;

    $display("[TB] reset readback");
    readReg(2'd1, rd); checkOutput("status_after_reset", rd, 32'h02);
    readReg(2'd2, rd); checkOutput("div_after_reset", rd, 32'd434);
    readReg(2'd0, rd); checkOutput("data_reads_zero", rd, 32'd0);
    readReg(2'd3, rd); checkOutput("addr3_reads_zero", rd, 32'd0);
    checkOutput("complete_after_reset", {31'd0, char_complete_tx}, 32'd0);

    $display("[TB] single frame 0x55 at div 4");
    writeReg(2'd2, 32'd4);
    readReg(2'd2, rd); checkOutput("div_readback_4", rd, 32'd4);
    pushFrame(8'h55, 4, 1'b1, 1'b0);
    writeReg(2'd0, 32'h55);
    waitIdle("single", 200);
    readReg(2'd1, rd); checkOutput("status_after_single", rd, 32'h03);
    writeReg(2'd1, 32'h01);
    readReg(2'd1, rd); checkOutput("status_after_clear", rd, 32'h02);
    checkOutput("complete_pin_cleared", {31'd0, char_complete_tx}, 32'd0);

    $display("[TB] back-to-back frames at div 2");
    writeReg(2'd2, 32'd2);
    pushFrame(8'hA0, 2, 1'b0, 1'b0);
    pushFrame(8'h0F, 2, 1'b0, 1'b1);
    pushFrame(8'hFF, 2, 1'b0, 1'b1);
    writeReg(2'd0, 32'hA0);
    writeReg(2'd0, 32'h0F);
    writeReg(2'd0, 32'hFF);
    waitIdle("b2b", 300);
    readReg(2'd1, rd); checkOutput("status_after_b2b", rd, 32'h03);
    writeReg(2'd1, 32'h01);

    $display("[TB] overflow burst at div 100");
    writeReg(2'd2, 32'd100);
    pushFrame(8'h11, 100, 1'b0, 1'b0);
    pushFrame(8'h22, 100, 1'b0, 1'b1);
    pushFrame(8'h33, 100, 1'b0, 1'b1);
    pushFrame(8'h44, 100, 1'b0, 1'b1);
    pushFrame(8'h55, 100, 1'b0, 1'b1);
    @(negedge clk);
    address    = 2'd0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      writedata = 32'(i * 8'h11);
      if (i < 6) @(negedge clk);
    end
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    readReg(2'd1, rd); checkOutput("status_overflow_full_busy", rd, 32'h1C);
    waitIdle("overflow", 7000);
    readReg(2'd1, rd); checkOutput("status_after_overflow_drain", rd, 32'h13);
    writeReg(2'd1, 32'h10);
    readReg(2'd1, rd); checkOutput("status_overflow_cleared", rd, 32'h03);
    writeReg(2'd1, 32'h01);
    readReg(2'd1, rd); checkOutput("status_all_cleared", rd, 32'h02);

    $display("[TB] clear racing frame completion");
    writeReg(2'd2, 32'd2);
    pushFrame(8'h3C, 2, 1'b1, 1'b0);
    writeReg(2'd0, 32'h3C);
    repeat (19) @(negedge clk);
    writeReg(2'd1, 32'h01);
    waitIdle("race", 100);
    readReg(2'd1, rd); checkOutput("status_set_wins", rd, 32'h03);
    writeReg(2'd1, 32'h01);
    checkOutput("complete_pin_late_clear", {31'd0, char_complete_tx}, 32'd0);

    $display("[TB] divisor change mid-frame");
    writeReg(2'd2, 32'd3);
    pushFrame(8'h01, 3, 1'b0, 1'b0);
    pushFrame(8'h5A, 1, 1'b0, 1'b1);
    writeReg(2'd0, 32'h01);
    repeat (5) @(negedge clk);
    writeReg(2'd2, 32'd0);
    writeReg(2'd0, 32'h5A);
    readReg(2'd2, rd); checkOutput("div_zero_stored_as_one", rd, 32'd1);
    waitIdle("divchange", 200);

    $display("[TB] reset mid-frame");
    monActive = 1'b0;
    writeReg(2'd2, 32'd4);
    writeReg(2'd0, 32'h00);
    writeReg(2'd0, 32'h88);
    repeat (10) @(negedge clk);
    checkOutput("tx_low_mid_frame", {31'd0, tx_serial}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("tx_high_on_reset", {31'd0, tx_serial}, 32'd1);
    checkOutput("complete_zero_on_reset", {31'd0, char_complete_tx}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    readReg(2'd1, rd); checkOutput("status_after_midframe_reset", rd, 32'h02);
    readReg(2'd2, rd); checkOutput("div_after_midframe_reset", rd, 32'd434);
    repeat (20) @(negedge clk);
    checkOutput("tx_idle_after_reset", {31'd0, tx_serial}, 32'd1);
    readReg(2'd1, rd); checkOutput("fifo_stays_empty", rd, 32'h02);
    monActive = 1'b1;

    checkOutput("all_expected_frames_seen", expQ.size(), 32'd0);
  endtask

  initial begin : stimulus
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
